// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execute sequencer: instruction field layout,
// datapath widths, FSM state encoding and the ALU opcode values.
package exec_sequencer_pkg;

  localparam int unsigned DataW    = 8;
  localparam int unsigned InstrW   = 16;
  localparam int unsigned OpW      = 5;
  localparam int unsigned RegAddrW = 3;
  localparam int unsigned NumRegs  = 8;

  // Instruction word: [15:11] op, [10:8] rd, [7:5] ra, [4] imm, [3:0] rb/imm4
  localparam int unsigned OpLsb   = 11;
  localparam int unsigned RdLsb   = 8;
  localparam int unsigned RaLsb   = 5;
  localparam int unsigned ImmBit  = 4;
  localparam int unsigned RbLsb   = 0;
  localparam int unsigned Imm4Lsb = 0;
  localparam int unsigned Imm4W   = 4;

  // ALU opcodes; values mirror the CPU's ALU decoder
  localparam logic [OpW-1:0] OpUad = 5'd0;
  localparam logic [OpW-1:0] OpUsb = 5'd1;
  localparam logic [OpW-1:0] OpUml = 5'd2;
  localparam logic [OpW-1:0] OpUdv = 5'd3;
  localparam logic [OpW-1:0] OpShl = 5'd4;
  localparam logic [OpW-1:0] OpShr = 5'd5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StExec = 2'd2,
    StWb   = 2'd3
  } state_e;

  function automatic logic [OpW-1:0] instr_op(input logic [InstrW-1:0] i);
    return i[OpLsb +: OpW];
  endfunction

  function automatic logic [RegAddrW-1:0] instr_rd(input logic [InstrW-1:0] i);
    return i[RdLsb +: RegAddrW];
  endfunction

  function automatic logic [RegAddrW-1:0] instr_ra(input logic [InstrW-1:0] i);
    return i[RaLsb +: RegAddrW];
  endfunction

  function automatic logic instr_imm(input logic [InstrW-1:0] i);
    return i[ImmBit];
  endfunction

  // rb[3] is deliberately dropped: only eight registers exist
  function automatic logic [RegAddrW-1:0] instr_rb(input logic [InstrW-1:0] i);
    return i[RbLsb +: RegAddrW];
  endfunction

  function automatic logic [Imm4W-1:0] instr_imm4(input logic [InstrW-1:0] i);
    return i[Imm4Lsb +: Imm4W];
  endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction handshake, ALU operand/result bus and writeback report of the
// execute sequencer. master = sequencer side, slave = fetch/ALU/CPU side.
interface exec_sequencer_if;

  logic                                   instr_valid;
  logic [exec_sequencer_pkg::InstrW-1:0]  instr;
  logic                                   instr_ready;
  logic [exec_sequencer_pkg::OpW-1:0]     alu_op;
  logic [exec_sequencer_pkg::DataW-1:0]   operand_a;
  logic [exec_sequencer_pkg::DataW-1:0]   operand_b;
  logic [exec_sequencer_pkg::DataW-1:0]   alu_result;
  logic                                   alu_shift_ovf;
  logic                                   alu_arith_ovf;
  logic                                   done;
  logic [exec_sequencer_pkg::RegAddrW-1:0] wb_addr;
  logic [exec_sequencer_pkg::DataW-1:0]   wb_data;

  modport master (
    input  instr_valid, instr, alu_result, alu_shift_ovf, alu_arith_ovf,
    output instr_ready, alu_op, operand_a, operand_b, done, wb_addr, wb_data
  );

  modport slave (
    output instr_valid, instr, alu_result, alu_shift_ovf, alu_arith_ovf,
    input  instr_ready, alu_op, operand_a, operand_b, done, wb_addr, wb_data
  );

endinterface

// File: rtl/exec_sequencer_reg_file.sv
// 8x8 register file: two combinational source read ports, a debug read port
// and one synchronous write port; synchronous reset clears every entry.
module exec_sequencer_reg_file
  import exec_sequencer_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [RegAddrW-1:0] ra_addr_i,
  output logic [DataW-1:0]    ra_data_o,
  input  logic [RegAddrW-1:0] rb_addr_i,
  output logic [DataW-1:0]    rb_data_o,
  input  logic [RegAddrW-1:0] dbg_addr_i,
  output logic [DataW-1:0]    dbg_data_o,
  input  logic                we_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic [DataW-1:0]    wdata_i
);

  logic [DataW-1:0] mem_q [NumRegs];

  // Storage update: clear on reset, otherwise single-port write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o  = mem_q[ra_addr_i];
  assign rb_data_o  = mem_q[rb_addr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execute sequencer: IDLE -> READ -> EXEC -> WB, one instruction
// per four cycles, feeding an external combinational ALU.
// Build option: STICKY_FLAGS_EN makes the status flags accumulate overflows
// until clear_flags or reset; otherwise they reflect the last writeback.
module exec_sequencer
  import exec_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  exec_sequencer_if.master    bus,
  input  logic                clear_flags,
  input  logic [RegAddrW-1:0] dbg_addr,
  output logic [DataW-1:0]    dbg_data,
  output logic                shift_flag,
  output logic                arith_flag
);

  state_e              state_q, state_d;
  logic [InstrW-1:0]   instr_q;
  logic [OpW-1:0]      alu_op_q;
  logic [DataW-1:0]    opa_q, opb_q;
  logic [DataW-1:0]    result_q;
  logic                shift_ovf_q, arith_ovf_q;
  logic                shift_flag_q, shift_flag_d;
  logic                arith_flag_q, arith_flag_d;
  logic [DataW-1:0]    ra_data, rb_data;
  logic                instr_ld;

  exec_sequencer_reg_file u_reg_file (
    .clk_i      (clk),
    .rst_i      (reset),
    .ra_addr_i  (instr_ra(instr_q)),
    .ra_data_o  (ra_data),
    .rb_addr_i  (instr_rb(instr_q)),
    .rb_data_o  (rb_data),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data),
    .we_i       (state_q == StWb),
    .waddr_i    (instr_rd(instr_q)),
    .wdata_i    (result_q)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and instruction-latch strobe
  always_comb begin
    state_d  = state_q;
    instr_ld = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.instr_valid) begin
          instr_ld = 1'b1;
          state_d  = StRead;
        end
      end
      StRead:  state_d = StExec;
      StExec:  state_d = StWb;
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers: instruction, registered ALU inputs, captured ALU outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q     <= '0;
      alu_op_q    <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      shift_ovf_q <= 1'b0;
      arith_ovf_q <= 1'b0;
    end else begin
      if (instr_ld) begin
        instr_q <= bus.instr;
      end
      if (state_q == StRead) begin
        alu_op_q <= instr_op(instr_q);
        opa_q    <= ra_data;
        opb_q    <= instr_imm(instr_q) ? {4'b0, instr_imm4(instr_q)} : rb_data;
      end
      if (state_q == StExec) begin
        result_q    <= bus.alu_result;
        shift_ovf_q <= bus.alu_shift_ovf;
        arith_ovf_q <= bus.alu_arith_ovf;
      end
    end
  end

  // Flag next-state: clear first, so a same-cycle writeback set still wins
  always_comb begin
    shift_flag_d = shift_flag_q;
    arith_flag_d = arith_flag_q;
    if (clear_flags) begin
      shift_flag_d = 1'b0;
      arith_flag_d = 1'b0;
    end
    if (state_q == StWb) begin
`ifdef STICKY_FLAGS_EN
      shift_flag_d = shift_flag_d | shift_ovf_q;
      arith_flag_d = arith_flag_d | arith_ovf_q;
`else
      shift_flag_d = shift_ovf_q;
      arith_flag_d = arith_ovf_q;
`endif
    end
  end

  // Status flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      shift_flag_q <= 1'b0;
      arith_flag_q <= 1'b0;
    end else begin
      shift_flag_q <= shift_flag_d;
      arith_flag_q <= arith_flag_d;
    end
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.alu_op      = alu_op_q;
  assign bus.operand_a   = opa_q;
  assign bus.operand_b   = opb_q;
  assign bus.done        = (state_q == StWb);
  assign bus.wb_addr     = instr_rd(instr_q);
  assign bus.wb_data     = result_q;
  assign shift_flag      = shift_flag_q;
  assign arith_flag      = arith_flag_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer with a behavioural ALU alongside it.
// Expected writebacks are queued at issue and popped when done pulses.
module tb_exec_sequencer;
  import exec_sequencer_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_flags;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       shift_flag, arith_flag;

  exec_sequencer_if bus ();

  exec_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .clear_flags (clear_flags),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .shift_flag  (shift_flag),
    .arith_flag  (arith_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] rd;
    logic [7:0] data;
  } wb_t;

  wb_t        sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] m_rf [8];
  logic       m_sf, m_af;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ALU behaviour; unknown opcodes give 0
  function automatic void alu_ref(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic so, output logic ao);
    logic [15:0] w;
    r  = 8'd0;
    so = 1'b0;
    ao = 1'b0;
    w  = 16'd0;
    case (op)
      OpUad: begin
        w  = {8'd0, a} + {8'd0, b};
        r  = w[7:0];
        ao = w[8];
      end
      OpShl: begin
        w  = {8'd0, a} << b[2:0];
        r  = w[7:0];
        so = |w[15:8];
      end
      OpUdv: begin
        if (b == 8'd0) begin
          r  = 8'hff;
          ao = 1'b1;
        end else begin
          r = a / b;
        end
      end
      default: ;
    endcase
  endfunction

  logic [7:0] alu_r;
  logic       alu_so, alu_ao;
  always_comb begin
    alu_r  = 8'd0;
    alu_so = 1'b0;
    alu_ao = 1'b0;
    alu_ref(bus.alu_op, bus.operand_a, bus.operand_b, alu_r, alu_so, alu_ao);
  end
  assign bus.alu_result    = alu_r;
  assign bus.alu_shift_ovf = alu_so;
  assign bus.alu_arith_ovf = alu_ao;

  // Scoreboard consumer
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        check_eq("done_unexpected", {31'd0, bus.done}, 32'd0);
      end else begin
        wb_t e;
        e = sb.pop_front();
        check_eq("wb_addr", {29'd0, bus.wb_addr}, {29'd0, e.rd});
        check_eq("wb_data", {24'd0, bus.wb_data}, {24'd0, e.data});
      end
    end
  end

  task automatic check_reg(input string tag, input logic [2:0] a, input logic [7:0] exp);
    dbg_addr = a;
    #1;
    check_eq(tag, {24'd0, dbg_data}, {24'd0, exp});
  endtask

  task automatic check_flags(input string tag, input logic es, input logic ea);
    check_eq({tag, "_shift"}, {31'd0, shift_flag}, {31'd0, es});
    check_eq({tag, "_arith"}, {31'd0, arith_flag}, {31'd0, ea});
  endtask

  task automatic run_instr(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] ra,
                           input logic imm, input logic [3:0] b, input logic clr_wb);
    logic [7:0] a_v, b_v, r;
    logic       so, ao;
    wb_t        e;
    a_v = m_rf[ra];
    b_v = imm ? {4'd0, b} : m_rf[b[2:0]];
    alu_ref(op, a_v, b_v, r, so, ao);
    @(negedge clk);
    check_eq("ready_idle", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr       = {op, rd, ra, imm, b};
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'($urandom);
    e.rd   = rd;
    e.data = r;
    sb.push_back(e);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_eq("ready_busy", {31'd0, bus.instr_ready}, 32'd0);
      check_eq("done_cycle", {31'd0, bus.done}, {31'd0, (k == 3)});
      if (k == 2) begin
        check_eq("alu_op", {27'd0, bus.alu_op}, {27'd0, op});
        check_eq("operand_a", {24'd0, bus.operand_a}, {24'd0, a_v});
        check_eq("operand_b", {24'd0, bus.operand_b}, {24'd0, b_v});
      end
      if (k == 3 && clr_wb) clear_flags = 1'b1;
    end
    @(posedge clk);
    #1;
    clear_flags = 1'b0;
    m_rf[rd] = r;
    if (clr_wb) begin
      m_sf = so;
      m_af = ao;
    end else begin
`ifdef STICKY_FLAGS_EN
      m_sf = m_sf | so;
      m_af = m_af | ao;
`else
      m_sf = so;
      m_af = ao;
`endif
    end
    check_flags("flags", m_sf, m_af);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [4:0] rnd_ops [4];

  initial begin
    reset           = 1'b1;
    clear_flags     = 1'b0;
    dbg_addr        = 3'd0;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'd0;
    for (int i = 0; i < 8; i++) m_rf[i] = 8'd0;
    m_sf = 1'b0;
    m_af = 1'b0;

    // Reset behaviour
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_ready", {31'd0, bus.instr_ready}, 32'd1);
    check_eq("rst_done", {31'd0, bus.done}, 32'd0);
    check_eq("rst_wb_data", {24'd0, bus.wb_data}, 32'd0);
    check_eq("rst_operand_a", {24'd0, bus.operand_a}, 32'd0);
    check_flags("rst", 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) check_reg("rst_reg", 3'(i), 8'd0);

    // Immediate add
    run_instr(OpUad, 3'd1, 3'd0, 1'b1, 4'd9, 1'b0);
    check_reg("r1_imm", 3'd1, 8'd9);

    // Build R1 = 200: 12, <<4 = 192, +8
    run_instr(OpUad, 3'd1, 3'd0, 1'b1, 4'd12, 1'b0);
    run_instr(OpShl, 3'd1, 3'd1, 1'b1, 4'd4, 1'b0);
    run_instr(OpUad, 3'd1, 3'd1, 1'b1, 4'd8, 1'b0);
    check_reg("r1_200", 3'd1, 8'd200);

    // Register add with carry out
    run_instr(OpUad, 3'd2, 3'd1, 1'b0, 4'd1, 1'b0);
    check_reg("r2_ovf", 3'd2, 8'h90);
    check_flags("ovf", 1'b0, 1'b1);

    // Non-overflowing op, then shift of MSB-set value
    run_instr(OpUad, 3'd4, 3'd0, 1'b1, 4'd1, 1'b0);
    run_instr(OpShl, 3'd5, 3'd2, 1'b1, 4'd1, 1'b0);
`ifdef STICKY_FLAGS_EN
    check_flags("accum", 1'b1, 1'b1);
`else
    check_flags("accum", 1'b1, 1'b0);
`endif
    check_reg("r5_shl", 3'd5, 8'd32);

    // clear_flags while idle
    @(negedge clk);
    clear_flags = 1'b1;
    @(posedge clk);
    #1;
    clear_flags = 1'b0;
    m_sf = 1'b0;
    m_af = 1'b0;
    check_flags("clr_idle", 1'b0, 1'b0);

    // Divide by zero with clear_flags coinciding with WB: set wins
    run_instr(OpUdv, 3'd6, 3'd1, 1'b1, 4'd0, 1'b1);
    check_flags("clr_wb", 1'b0, 1'b1);
    check_reg("r6_div0", 3'd6, 8'hff);

    // Back-to-back dependent instructions
    run_instr(OpUad, 3'd7, 3'd5, 1'b1, 4'd3, 1'b0);
    run_instr(OpUad, 3'd7, 3'd7, 1'b1, 4'd3, 1'b0);
    check_reg("r7_dep", 3'd7, 8'd38);

    // Random mix including an unrecognised opcode and rb[3] set
    rnd_ops[0] = OpUad;
    rnd_ops[1] = OpShl;
    rnd_ops[2] = OpUdv;
    rnd_ops[3] = 5'd31;
    for (int n = 0; n < 8; n++) begin
      run_instr(rnd_ops[$urandom_range(0, 3)], 3'($urandom), 3'($urandom), 1'($urandom),
                4'($urandom), 1'b0);
    end

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    check_eq("abort_ready", {31'd0, bus.instr_ready}, 32'd1);
    bus.instr       = {OpUad, 3'd3, 3'd1, 1'b1, 4'd1};
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_read_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    check_eq("abort_exec_done", {31'd0, bus.done}, 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) m_rf[i] = 8'd0;
    m_sf = 1'b0;
    m_af = 1'b0;
    @(negedge clk);
    check_eq("abort_idle", {31'd0, bus.instr_ready}, 32'd1);
    check_eq("abort_done", {31'd0, bus.done}, 32'd0);
    check_reg("abort_r3", 3'd3, 8'd0);
    check_flags("abort", 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    check_reg("abort_r3_late", 3'd3, 8'd0);

    // Recovery after abort
    run_instr(OpUad, 3'd3, 3'd0, 1'b1, 4'd5, 1'b0);
    check_reg("r3_recover", 3'd3, 8'd5);

    repeat (2) @(posedge clk);
    check_eq("sb_drain", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
